// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit controller. Accepts a byte via tx_start/busy,
//            then serialises start, LSB-first data, parity and stop fields,
//            each CLKS_PER_BIT clocks long. Drives the external TX mux via
//            select/data_bit/parity_bit.
// Ports    : clk        - clock, rising edge
//            rst_n      - synchronous active-low reset
//            tx_start   - send request, honoured only in IDLE
//            tx_data    - payload captured in the accept cycle
//            busy       - frame in progress (START..STOP)
//            done       - one-cycle pulse in first IDLE cycle after STOP
//            select     - mux field code: 00 start, 01 data, 10 parity,
//                         11 stop/idle
//            data_bit   - shift register bit 0
//            parity_bit - registered parity of captured payload
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           select,
    output logic                 data_bit,
    output logic                 parity_bit
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] c_cnt_max = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] c_idx_max = IW'(DATA_BITS - 1);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_start  = 3'd1;
    localparam logic [2:0] c_s_data   = 3'd2;
    localparam logic [2:0] c_s_parity = 3'd3;
    localparam logic [2:0] c_s_stop   = 3'd4;

    localparam logic [1:0] c_sel_start  = 2'b00;
    localparam logic [1:0] c_sel_data   = 2'b01;
    localparam logic [1:0] c_sel_parity = 2'b10;
    localparam logic [1:0] c_sel_stop   = 2'b11;

    logic [2:0]           r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [1:0]           r_select;
    logic                 r_busy;
    logic                 r_done;
    logic                 w_bit_end;

    assign w_bit_end = (r_cnt == c_cnt_max);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= c_s_idle;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_select <= c_sel_stop;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Every bit-end transition clears the counter; otherwise it runs.
            if (r_state != c_s_idle) begin
                r_cnt <= w_bit_end ? '0 : r_cnt + 1'b1;
            end
            case (r_state)
                c_s_idle: begin
                    r_cnt <= '0;
                    if (tx_start) begin
                        r_shift  <= tx_data;
                        r_parity <= PARITY_ODD ? ~^tx_data : ^tx_data;
                        r_idx    <= '0;
                        r_state  <= c_s_start;
                        r_select <= c_sel_start;
                        r_busy   <= 1'b1;
                    end
                end
                c_s_start: begin
                    if (w_bit_end) begin
                        r_state  <= c_s_data;
                        r_select <= c_sel_data;
                    end
                end
                c_s_data: begin
                    if (w_bit_end) begin
                        // The last data bit is left in place; no shift on exit.
                        if (r_idx == c_idx_max) begin
                            r_state  <= c_s_parity;
                            r_select <= c_sel_parity;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 1'b1;
                        end
                    end
                end
                c_s_parity: begin
                    if (w_bit_end) begin
                        r_state  <= c_s_stop;
                        r_select <= c_sel_stop;
                    end
                end
                c_s_stop: begin
                    if (w_bit_end) begin
                        r_state <= c_s_idle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_s_idle;
                    r_select <= c_sel_stop;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign select     = r_select;
    assign data_bit   = r_shift[0];
    assign parity_bit = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Directed self-checking bench for uart_tx_ctrl (CLKS_PER_BIT=4,
//            DATA_BITS=8) with an even-parity and an odd-parity instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       busy, done, data_bit, parity_bit;
    logic [1:0] select;

    logic       tx_start_o = 1'b0;
    logic [7:0] tx_data_o = 8'h00;
    logic       busy_o, done_o, data_bit_o, parity_bit_o;
    logic [1:0] select_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_ODD(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start), .tx_data(tx_data),
        .busy(busy), .done(done), .select(select),
        .data_bit(data_bit), .parity_bit(parity_bit)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .tx_start(tx_start_o), .tx_data(tx_data_o),
        .busy(busy_o), .done(done_o), .select(select_o),
        .data_bit(data_bit_o), .parity_bit(parity_bit_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge while IDLE; returns in the first START cycle.
    task automatic start_frame(input logic [7:0] b);
        tx_start = 1'b1;
        tx_data  = b;
        step();
        tx_start = 1'b0;
    endtask

    // Checks a full 44-cycle frame starting in its first START cycle, then
    // the done cycle. Returns at #1 into the done cycle.
    task automatic run_frame(input logic [7:0] b, input logic exp_par, input bit inject);
        logic [1:0] exp_sel;
        for (int c = 0; c < 44; c++) begin
            exp_sel = (c < 4) ? 2'b00 : (c < 36) ? 2'b01 : (c < 40) ? 2'b10 : 2'b11;
            checks++;
            if (select !== exp_sel) begin
                errors++;
                $display("FAIL frame_select byte=%h cycle=%0d got=%b exp=%b", b, c, select, exp_sel);
            end
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL frame_busy_done byte=%h cycle=%0d got busy=%b done=%b exp busy=1 done=0", b, c, busy, done);
            end
            if (c >= 4 && c < 36) begin
                checks++;
                if (data_bit !== b[(c-4)/4]) begin
                    errors++;
                    $display("FAIL frame_data_bit byte=%h slot=%0d got=%b exp=%b", b, (c-4)/4, data_bit, b[(c-4)/4]);
                end
            end
            if (c >= 36 && c < 40) begin
                checks++;
                if (parity_bit !== exp_par) begin
                    errors++;
                    $display("FAIL frame_parity byte=%h got=%b exp=%b", b, parity_bit, exp_par);
                end
            end
            if (inject && c == 10) begin
                tx_start = 1'b1;
                tx_data  = 8'h00;
            end
            step();
            if (inject && c == 10) tx_start = 1'b0;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || select !== 2'b11) begin
            errors++;
            $display("FAIL frame_done byte=%h got done=%b busy=%b sel=%b exp done=1 busy=0 sel=11", b, done, busy, select);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (select !== 2'b11 || busy !== 1'b0 || done !== 1'b0 || data_bit !== 1'b0 || parity_bit !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got sel=%b busy=%b done=%b db=%b pb=%b exp sel=11 others 0",
                     select, busy, done, data_bit, parity_bit);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (select !== 2'b11 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold got sel=%b busy=%b exp sel=11 busy=0", select, busy);
        end
    endtask

    task automatic test_basic_frame();
        start_frame(8'hA5);
        run_frame(8'hA5, 1'b0, 1'b0);
        step();
        checks++;
        if (done !== 1'b0 || select !== 2'b11) begin
            errors++;
            $display("FAIL basic_idle_after got done=%b sel=%b exp done=0 sel=11", done, select);
        end
    endtask

    task automatic test_parity();
        tx_start_o = 1'b1;
        tx_data_o  = 8'h07;
        start_frame(8'h07);
        tx_start_o = 1'b0;
        checks++;
        if (parity_bit_o !== 1'b0 || select_o !== 2'b00) begin
            errors++;
            $display("FAIL odd_parity got pb=%b sel=%b exp pb=0 sel=00", parity_bit_o, select_o);
        end
        checks++;
        if (parity_bit !== 1'b1) begin
            errors++;
            $display("FAIL even_parity_07 got=%b exp=1", parity_bit);
        end
        run_frame(8'h07, 1'b1, 1'b0);
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL odd_done got=%b exp=1", done_o);
        end
        step();
    endtask

    task automatic test_back_to_back();
        start_frame(8'hFF);
        run_frame(8'hFF, 1'b0, 1'b0);
        start_frame(8'h3C);
        run_frame(8'h3C, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_ignore_busy();
        start_frame(8'h55);
        run_frame(8'h55, 1'b0, 1'b1);
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || select !== 2'b11) begin
            errors++;
            $display("FAIL ignore_single_done got done=%b busy=%b sel=%b exp 0 0 11", done, busy, select);
        end
    endtask

    task automatic test_reset_mid_frame();
        start_frame(8'hD9);
        for (int c = 0; c < 37; c++) step();
        checks++;
        if (select !== 2'b10 || parity_bit !== 1'b1 || data_bit !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_parity got sel=%b pb=%b db=%b exp sel=10 pb=1 db=1", select, parity_bit, data_bit);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (select !== 2'b11 || busy !== 1'b0 || data_bit !== 1'b0 || parity_bit !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got sel=%b busy=%b db=%b pb=%b done=%b exp sel=11 others 0",
                     select, busy, data_bit, parity_bit, done);
        end
        step();
        checks++;
        if (done !== 1'b0 || select !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_no_done got done=%b sel=%b exp done=0 sel=11", done, select);
        end
        start_frame(8'h81);
        run_frame(8'h81, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller. It accepts a parallel byte through a start/busy handshake and serialises it as a frame: start bit, LSB-first data bits, parity bit, stop bit, each lasting `CLKS_PER_BIT` clocks. It drives the transmit output multiplexer directly through three signals: `select` (frame field code), `data_bit` (current PISO bit) and `parity_bit` (computed parity). It owns the baud timing, the frame state machine, the shift register and the parity computation.

## Interface
- `CLKS_PER_BIT`, default 16: clocks per serial bit; must be ≥ 2.
- `DATA_BITS`, default 8: payload width, 5..8.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.

Ports:
- `clk`  in  1: single clock; all logic on the rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `tx_start`  in  1: request to send `tx_data`; sampled only in IDLE.
- `tx_data`  in  DATA_BITS: payload, captured in the accept cycle.
- `busy`  out  1: frame in progress (START..STOP).
- `done`  out  1: one-cycle pulse after the stop bit completes.
- `select`  out  2: field code to the mux: 00 start, 01 data, 10 parity, 11 stop/idle.
- `data_bit`  out  1: shift register bit 0.
- `parity_bit`  out  1: registered parity of the captured byte.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- `select` per state: IDLE=11, START=00, DATA=01, PARITY=10, STOP=11. Because IDLE drives 11, the line idles high.
- Baud counter: width `$clog2(CLKS_PER_BIT)`.
  - Clears on every state entry.
  - A bit ends when the counter equals `CLKS_PER_BIT-1`.
- IDLE: `tx_start`=1 causes, at that edge:
  - the shift register loads `tx_data`;
  - `parity_bit` loads `^tx_data`, or `~^tx_data` if `PARITY_ODD`=1;
  - the bit index resets to 0;
  - the next state is START.
- START: at bit end, go to DATA.
- DATA:
  - At each bit end, the shift register shifts right (fills with 0) and the bit index increments.
  - After bit `DATA_BITS-1` ends, go to PARITY without shifting.
- PARITY: at bit end, go to STOP.
- STOP: at bit end, go to IDLE and assert `done` for exactly one cycle.
- `busy` = 1 whenever the state is not IDLE.
- `tx_start` while busy is ignored. There is no queuing, and `tx_data` changes during a frame have no effect.
- `tx_start` in the same cycle that `done` is high is accepted, because the state is already IDLE. This gives back-to-back frames with no idle gap.
- `data_bit` and `parity_bit` hold their values outside their fields; they are only sampled by the mux when `select` picks them.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state goes to IDLE;
  - `select`=11, `busy`=0, `done`=0;
  - shift register = 0, so `data_bit`=0;
  - `parity_bit`=0, counters = 0.
- Reset mid-frame aborts the frame immediately at that edge. The line returns to 11, and no `done` is issued.
- Latency: accept edge → `select`=00 and `busy`=1 in the next cycle.
- Each field is held for exactly `CLKS_PER_BIT` cycles.
- Full frame: `(DATA_BITS+3)*CLKS_PER_BIT` cycles from the first START cycle to the first IDLE cycle. This is 44 cycles for `CLKS_PER_BIT`=4 and `DATA_BITS`=8.
- `done` is high during the first IDLE cycle after STOP.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic frame, even parity:
  - Stimulus: `CLKS_PER_BIT`=4, `PARITY_ODD`=0, send 0xA5.
  - Required `select` run: 00×4, 01×32, 10×4, 11×4.
  - Required `data_bit` per data slot: 1,0,1,0,0,1,0,1.
  - Required `parity_bit`=0; `done` pulses once, at cycle 44 after START entry.
- Odd parity:
  - Stimulus: `PARITY_ODD`=1, send 0x07.
  - Required: `parity_bit`=0. With `PARITY_ODD`=0 the same byte gives `parity_bit`=1.
- Back-to-back:
  - Stimulus: assert `tx_start` with 0x3C in the `done` cycle of a 0xFF frame.
  - Required: the next cycle shows `select`=00; `busy` is low only in the `done` cycle.
- Ignore while busy:
  - Stimulus: pulse `tx_start` with 0x00 during the DATA field of a 0x55 frame.
  - Required: the frame completes as 0x55, and only one `done` is issued.
- Reset mid-frame:
  - Stimulus: drive `rst_n` low for 1 cycle during the PARITY field.
  - Required at the next cycle: `select`=11, `busy`=0, `data_bit`=0, `parity_bit`=0, and no `done`.
  - A subsequent 0x81 frame then transmits correctly.
